// File: rtl/bcd_convert_arbiter.sv
// -----------------------------------------------------------------------------
// bcd_convert_arbiter
//
// Shared binary-to-BCD converter serving four requesters. Requests are
// arbitrated round-robin. The granted channel's 8-bit operand is captured and
// converted with an 8-step double-dabble sequence. The three decimal digits are
// then presented together with the originating channel index.
//
// Ports
//   clk       in   1   single clock, all state updates on the rising edge
//   rst       in   1   synchronous, active-high reset
//   req       in   4   req[i] high = channel i wants a conversion
//   bin_in    in  32   channel i operand at bin_in[8i+7:8i], stable while req[i]
//   ack       out  4   one-hot, one-cycle pulse: operand of that channel captured
//   busy      out  1   high while a conversion is in progress (SHIFT state)
//   done      out  1   one-cycle pulse: ones/tens/hundreds/done_id are valid
//   done_id   out  2   channel index of the last completed conversion
//   ones      out  4   BCD units digit of the last result
//   tens      out  4   BCD tens digit of the last result
//   hundreds  out  4   BCD hundreds digit of the last result (0..2)
//
// Timing: ack is high in the first SHIFT cycle. Eight SHIFT edges follow, and
// done is high in the cycle after the eighth. That cycle is already IDLE, so a
// request still pending there is granted at the end of it. The result is one
// conversion every 9 cycles.
// -----------------------------------------------------------------------------
module bcd_convert_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] bin_in,
  output logic [3:0]  ack,
  output logic        busy,
  output logic        done,
  output logic [1:0]  done_id,
  output logic [3:0]  ones,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      state, state_nxt;
  logic [1:0]  last_gnt, last_gnt_nxt;   // channel granted most recently
  logic [1:0]  cur_id, cur_id_nxt;       // channel owning the running conversion
  logic [2:0]  cnt, cnt_nxt;             // completed double-dabble iterations
  logic [11:0] bcd, bcd_nxt;             // hundreds | tens | ones accumulator
  logic [7:0]  sr, sr_nxt;               // operand bits still to be shifted in
  logic [3:0]  ack_nxt;
  logic        done_nxt;
  logic [1:0]  done_id_nxt;
  logic [3:0]  ones_nxt, tens_nxt, hundreds_nxt;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: start the search one past the last grant and wrap.
  // The offset runs 1..4, and 2'(4) wraps to 0, so the channel granted last is
  // examined last.
  // ---------------------------------------------------------------------------
  logic       gnt_valid;
  logic [1:0] gnt_sel;
  logic [1:0] cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_sel   = last_gnt;
    cand      = last_gnt;
    for (int k = 1; k <= 4; k++) begin
      cand = last_gnt + 2'(k);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_sel   = cand;
      end
    end
  end

  logic [7:0] gnt_operand;
  assign gnt_operand = bin_in[{gnt_sel, 3'b000} +: 8];

  // ---------------------------------------------------------------------------
  // Double-dabble step: add 3 to every nibble >= 5, then shift the
  // {bcd, sr} pair left by one so the operand MSB enters the ones digit.
  // ---------------------------------------------------------------------------
  function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int n = 0; n < 3; n++) begin
      if (b[4*n +: 4] >= 4'd5) r[4*n +: 4] = b[4*n +: 4] + 4'd3;
    end
    return r;
  endfunction

  logic [11:0] bcd_adj;
  logic [11:0] bcd_shifted;
  logic [7:0]  sr_shifted;

  always_comb begin
    bcd_adj     = dabble_adjust(bcd);
    bcd_shifted = {bcd_adj[10:0], sr[7]};
    sr_shifted  = {sr[6:0], 1'b0};
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch. Otherwise a path
    // that leaves a signal unassigned infers a latch.
    state_nxt    = state;
    last_gnt_nxt = last_gnt;
    cur_id_nxt   = cur_id;
    cnt_nxt      = cnt;
    bcd_nxt      = bcd;
    sr_nxt       = sr;
    ack_nxt      = 4'b0000;
    done_nxt     = 1'b0;
    done_id_nxt  = done_id;
    ones_nxt     = ones;
    tens_nxt     = tens;
    hundreds_nxt = hundreds;

    unique case (state)
      IDLE: begin
        if (gnt_valid) begin
          ack_nxt      = 4'b0001 << gnt_sel;
          last_gnt_nxt = gnt_sel;
          cur_id_nxt   = gnt_sel;
          sr_nxt       = gnt_operand;
          bcd_nxt      = 12'd0;
          cnt_nxt      = 3'd0;
          state_nxt    = SHIFT;
        end
      end

      SHIFT: begin
        // req is deliberately ignored here; only IDLE arbitrates.
        bcd_nxt = bcd_shifted;
        sr_nxt  = sr_shifted;
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd7) begin
          // The eighth step's digits go straight to the result outputs.
          ones_nxt     = bcd_shifted[3:0];
          tens_nxt     = bcd_shifted[7:4];
          hundreds_nxt = bcd_shifted[11:8];
          done_id_nxt  = cur_id;
          done_nxt     = 1'b1;
          state_nxt    = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers. Reset has priority over every input in the same cycle, and it
  // aborts a running conversion without producing a done pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Each register then
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state    <= IDLE;
      last_gnt <= 2'd3;
      cur_id   <= 2'd0;
      cnt      <= 3'd0;
      bcd      <= 12'd0;
      sr       <= 8'd0;
      ack      <= 4'b0000;
      done     <= 1'b0;
      done_id  <= 2'd0;
      ones     <= 4'd0;
      tens     <= 4'd0;
      hundreds <= 4'd0;
    end else begin
      state    <= state_nxt;
      last_gnt <= last_gnt_nxt;
      cur_id   <= cur_id_nxt;
      cnt      <= cnt_nxt;
      bcd      <= bcd_nxt;
      sr       <= sr_nxt;
      ack      <= ack_nxt;
      done     <= done_nxt;
      done_id  <= done_id_nxt;
      ones     <= ones_nxt;
      tens     <= tens_nxt;
      hundreds <= hundreds_nxt;
    end
  end

  assign busy = (state == SHIFT);

  // ---------------------------------------------------------------------------
  // Design invariants
  // ---------------------------------------------------------------------------
  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
  a_ack_done_excl: assert property (@(posedge clk) disable iff (rst) !(done && (ack != 4'b0000)));
  a_digit_range: assert property (@(posedge clk) disable iff (rst)
                                  (ones <= 4'd9) && (tens <= 4'd9) && (hundreds <= 4'd2));

endmodule

// File: doc/bcd_convert_arbiter.md
BCD_CONVERT_ARBITER -- requirements
Module: bcd_convert_arbiter

Interface
REQ-001 The block SHALL have no parameters; it serves exactly 4 requesters with 8-bit binary inputs.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req  input  4  req[i] high = channel i requests a conversion.
REQ-005 bin_in  input  32  channel i operand at bin_in[8i+7:8i]; must be stable while req[i] is high.
REQ-006 ack  output  4  one-hot, one-cycle pulse: channel's operand captured; at most one bit high.
REQ-007 busy  output  1  high while a conversion is in progress (SHIFT state).
REQ-008 done  output  1  one-cycle pulse: result valid.
REQ-009 done_id  output  2  channel index of the completed conversion; held until next done.
REQ-010 ones, tens, hundreds  output  4 each  BCD digits of the result; held until next done.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-012 In IDLE with any req high, at the clock edge the block SHALL:
- grant one channel g
- capture bin_in[g]
- register ack[g]=1 for the next cycle
- go to SHIFT
REQ-013 In IDLE with req==0, the block SHALL stay in IDLE with ack=0.
REQ-014 Arbitration SHALL be round-robin: search starts at (last_gnt+1) mod 4, ascending with wrap; last_gnt updates to g on every grant.
REQ-015 req SHALL be sampled only in IDLE; req changes during SHIFT SHALL have no effect.
REQ-016 SHIFT SHALL run a double-dabble iteration over a 12-bit BCD register and an 8-bit shift register.
- On each of exactly 8 edges: add 3 to every BCD nibble >= 5, then shift left by one, MSB of operand first.
- A 3-bit counter tracks iterations.
REQ-017 On the 8th SHIFT edge, the block SHALL:
- load ones/tens/hundreds with the final digits
- load done_id with g
- assert done for one cycle
- return to IDLE
REQ-018 Latency: done SHALL be high exactly 8 cycles after the cycle in which ack is high; throughput is one conversion per 9 cycles.
REQ-019 A req still high in the first IDLE cycle after done SHALL be treated as a new request. Requesters drop req on seeing ack.
REQ-020 Result range SHALL be 0..255; hundreds SHALL never exceed 2, and no digit SHALL exceed 9.
REQ-021 busy SHALL be high from the ack cycle through the cycle before done, and low in the done cycle.
REQ-022 done and ack SHALL never be high in the same cycle.

Reset
REQ-023 While rst is high at an edge, the block SHALL set:
- state=IDLE, last_gnt=3 (so channel 0 has first priority)
- ack=0, done=0, busy=0
- ones=tens=hundreds=0, done_id=0
- counter and shift registers cleared
REQ-024 rst asserted during SHIFT SHALL abort the conversion with no done pulse. The first IDLE cycle after rst deasserts SHALL accept new requests.
REQ-025 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Single request: req=0001, bin_in[7:0]=10 -> ack=0001 next cycle; 8 cycles later done=1, done_id=0, hundreds/tens/ones = 0/1/0.
- Channel 1 with 204, then channel 2 with 139, then channel 3 with 255, then channel 0 with 0 -> digits 2/0/4, 1/3/9, 2/5/5 and 0/0/0, with matching done_id values.
- All four req held high from reset, each dropped on its ack -> grant order 0,1,2,3; done pulses 9 cycles apart.
- req[0] and req[2] re-asserted immediately after each ack -> grants alternate 0,2,0,2; channels 1 and 3 never acked.
- rst pulsed 4 cycles after ack -> no done; outputs 0. A following request on channel 1 with value 99 -> 0/9/9, done_id=1.
- Exhaustive: values 0..255 on a rotating channel -> every result matches decimal digits, ack is one-hot, and REQ-022 holds throughout.
